// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock frequency monitor: FSM encoding and the
// default gate/range constants for the 100 MHz board clock.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_e;

    // 1 ms gate at 100 MHz; 25 MHz nominal monitored rate gives 25000 edges.
    localparam int DEF_GATE_CYCLES  = 100000;
    localparam int DEF_CNT_W        = 20;
    localparam int DEF_EXP_MIN      = 24000;
    localparam int DEF_EXP_MAX      = 26000;
    localparam int DEF_LOCK_WINDOWS = 3;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by an edge register; rise is a one-cycle
// pulse on each synchronized low-to-high transition of din.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of an asynchronous signal over back-to-back gate
// windows, reports each count and derives in-range / locked / lost status.
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int EXP_MIN      = DEF_EXP_MIN,
    parameter int EXP_MAX      = DEF_EXP_MAX,
    parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mon_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lost
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  EXP_MIN_C = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  EXP_MAX_C = CNT_W'(EXP_MAX);
    localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_WINDOWS);

    logic rise;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mon_in),
        .rise (rise)
    );

    mon_state_e        state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              in_range_q, in_range_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;

    logic              win_end;
    logic              hit;
    logic [CNT_W-1:0]  edge_sum;
    logic [GOOD_W-1:0] good_inc;

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_d     = edge_q;
        good_d     = good_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        locked_d   = locked_q;
        lost_d     = 1'b0;

        win_end  = (gate_q == GATE_LAST);
        // Edge seen in the last gate cycle still belongs to the closing window.
        edge_sum = (rise && (edge_q != CNT_MAX)) ? edge_q + CNT_W'(1) : edge_q;
        hit      = (edge_sum >= EXP_MIN_C) && (edge_sum <= EXP_MAX_C);
        good_inc = (good_q == LOCK_C) ? good_q : good_q + GOOD_W'(1);

        if (!enable) begin
            state_d  = ST_IDLE;
            gate_d   = '0;
            edge_d   = '0;
            good_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The enabling cycle is gate cycle 0 of the warm-up window.
                    state_d = ST_WARMUP;
                    gate_d  = GATE_W'(1);
                    edge_d  = '0;
                end
                ST_WARMUP: begin
                    if (win_end) begin
                        state_d = ST_MEASURE;
                        gate_d  = '0;
                        edge_d  = '0;
                    end else begin
                        gate_d = gate_q + GATE_W'(1);
                        edge_d = edge_sum;
                    end
                end
                ST_MEASURE: begin
                    if (win_end) begin
                        gate_d     = '0;
                        edge_d     = '0;
                        count_d    = edge_sum;
                        valid_d    = 1'b1;
                        in_range_d = hit;
                        if (hit) begin
                            good_d   = good_inc;
                            locked_d = (good_inc == LOCK_C);
                        end else begin
                            good_d   = '0;
                            locked_d = 1'b0;
                            lost_d   = locked_q;
                        end
                    end else begin
                        gate_d = gate_q + GATE_W'(1);
                        edge_d = edge_sum;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            edge_q     <= '0;
            good_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            good_q     <= good_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign in_range    = in_range_q;
    assign locked      = locked_q;
    assign lost        = lost_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor with a 1000-cycle gate and a 98..102
// window; mon_in comes from a clk-derived pattern generator on the falling edge.
module tb_clk_freq_monitor;

    localparam int GATE  = 1000;
    localparam int CNT_W = 20;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic mon_in = 1'b0;

    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             in_range;
    logic             locked;
    logic             lost;

    always #5 clk = ~clk;

    clk_freq_monitor #(
        .GATE_CYCLES  (GATE),
        .CNT_W        (CNT_W),
        .EXP_MIN      (98),
        .EXP_MAX      (102),
        .LOCK_WINDOWS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mon_in      (mon_in),
        .count       (count),
        .count_valid (count_valid),
        .in_range    (in_range),
        .locked      (locked),
        .lost        (lost)
    );

    // Pattern generator: period 0 drives gen_level, otherwise low for the
    // first half of each period and high for the second. Bumping gen_epoch
    // restarts the phase at 0 on the next falling edge.
    int   gen_period = 0;
    logic gen_level  = 1'b0;
    int   gen_epoch  = 0;
    int   seen_epoch = 0;
    int   ph         = 0;

    always @(negedge clk) begin
        if (gen_epoch != seen_epoch) begin
            seen_epoch = gen_epoch;
            ph = 0;
        end else if (gen_period > 0) begin
            ph = (ph + 1 >= gen_period) ? 0 : ph + 1;
        end
        if (gen_period == 0) mon_in = gen_level;
        else                 mon_in = (ph >= gen_period / 2);
    end

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [CNT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_report(input string tag, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!count_valid && n < budget);
        check({tag, "_seen"}, count_valid, 1);
    endtask

    task automatic start_pattern(input int period);
        gen_period = period;
        gen_epoch++;
    endtask

    int n;
    int j;
    int reports;
    int lost_seen;
    int valid_seen;
    logic [CNT_W-1:0] win_a;
    logic [CNT_W-1:0] win_b;

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_valid", count_valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        rst = 1'b0;
        tick();

        // nominal rate: 100 rising edges per window, lock on the third report
        start_pattern(10);
        enable = 1'b1;
        wait_report("first", 2500, n);
        check("first_latency", n, 2 * GATE);
        check("first_count", count, 100);
        check("first_in_range", in_range, 1);
        check("first_locked", locked, 0);
        wait_report("second", 1500, n);
        check("second_interval", n, GATE);
        check("second_locked", locked, 0);
        wait_report("third", 1500, n);
        check("third_count", count, 100);
        check("third_locked", locked, 1);

        // period 12: first window after the change loses lock
        start_pattern(12);
        wait_report("slow", 1500, n);
        check("slow_count", count, 83);
        check("slow_in_range", in_range, 0);
        check("slow_locked", locked, 0);
        check("slow_lost", lost, 1);
        tick();
        check("slow_lost_pulse", lost, 0);
        check("slow_valid_pulse", count_valid, 0);
        wait_report("slow2", 1500, n);
        check("slow2_count", count, 83);

        // fastest measurable rate: one edge every 2 cycles
        start_pattern(2);
        wait_report("fast_skip", 1500, n);
        wait_report("fast", 1500, n);
        check("fast_count", count, 500);
        check("fast_in_range", in_range, 0);
        check("fast_locked", locked, 0);

        // constant input
        gen_period = 0;
        gen_level  = 1'b0;
        wait_report("const_skip", 1500, n);
        wait_report("const", 1500, n);
        check("const_count", count, 0);
        check("const_in_range", in_range, 0);

        // window boundary: pulses at offsets 100 and 997 land in window A
        // (997 on its last gate cycle), 999 and 1500 in window B
        exp_q.push_back(CNT_W'(2));
        exp_q.push_back(CNT_W'(2));
        j = 0;
        reports = 0;
        win_a = '0;
        win_b = '0;
        while (reports < 2 && j < 2500) begin
            tick();
            j++;
            gen_level = (j == 100) || (j == 997) || (j == 999) || (j == 1500);
            if (count_valid) begin
                reports++;
                if (reports == 1) win_a = count;
                else              win_b = count;
                if (exp_q.size() > 0) check("boundary_window", count, exp_q.pop_front());
            end
        end
        gen_level = 1'b0;
        check("boundary_reports", reports, 2);
        check("boundary_sum", win_a + win_b, 4);

        // reset in the middle of a MEASURE window
        start_pattern(10);
        wait_report("pre_rst", 1500, n);
        check("pre_rst_count", count, 100);
        repeat (500) tick();
        rst = 1'b1;
        tick();
        check("midrst_count", count, 0);
        check("midrst_valid", count_valid, 0);
        check("midrst_in_range", in_range, 0);
        check("midrst_locked", locked, 0);
        check("midrst_lost", lost, 0);
        rst = 1'b0;
        wait_report("post_rst", 2500, n);
        check("post_rst_latency", n, 2 * GATE);
        check("post_rst_count", count, 100);
        check("post_rst_in_range", in_range, 1);

        // drop enable while locked
        wait_report("relock2", 1500, n);
        wait_report("relock3", 1500, n);
        check("relock_locked", locked, 1);
        repeat (10) tick();
        enable = 1'b0;
        tick();
        check("dis_locked", locked, 0);
        check("dis_lost", lost, 0);
        check("dis_count", count, 100);
        check("dis_in_range", in_range, 1);
        lost_seen = 0;
        valid_seen = 0;
        repeat (1500) begin
            tick();
            if (lost) lost_seen++;
            if (count_valid) valid_seen++;
        end
        check("dis_no_lost", lost_seen, 0);
        check("dis_no_report", valid_seen, 0);
        check("dis_count_hold", count, 100);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
